// File: rtl/linebuffer_scanout.sv
// Ping-pong scanline buffer: drawers fill one bank while the other
// is scanned out to VGA and cleared behind the beam.
module linebuffer_scanout #(
   parameter int              WIDTH    = 640,
   parameter int              PIX_W    = 16,
   parameter logic [PIX_W-1:0] BG_COLOR = 16'h0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             line_start,
   input  logic             wr_en,
   input  logic [9:0]       wr_addr,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             draw_done,
   input  logic             rd_en,
   input  logic [9:0]       rd_addr,
   output logic [PIX_W-1:0] pixel_out,
   output logic             draw_start,
   output logic             ready,
   output logic             draw_bank,
   output logic             overrun
);

   typedef enum logic {
      INIT_CLEAR,
      RUN
   } state_t;

   localparam logic [9:0]  LAST = 10'(WIDTH - 1);
   localparam logic [10:0] W11  = 11'(WIDTH);

   state_t state, state_nx;
   logic [9:0] cnt, cnt_nx;
   logic init_done;

   logic [PIX_W-1:0] mem0 [WIDTH];
   logic [PIX_W-1:0] mem1 [WIDTH];

   logic start_pend;
   logic done;
   logic clr_pend;
   logic clr_bank;
   logic [9:0] clr_addr;

   logic run, swap, wr_ok, rd_hit;
   logic w0, w1, c0, c1;
   logic [9:0] caddr;
   logic [PIX_W-1:0] rd_word;

   assign run    = (state == RUN);
   assign swap   = run && line_start;
   assign wr_ok  = run && wr_en && ({1'b0, wr_addr} < W11);
   assign rd_hit = run && rd_en && ({1'b0, rd_addr} < W11);

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      init_done = 1'b0;
      unique case (state)
         INIT_CLEAR: begin
            cnt_nx = cnt + 10'd1;
            if (cnt == LAST) begin
               state_nx  = RUN;
               cnt_nx    = '0;
               init_done = 1'b1;
            end
         end
         RUN: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= INIT_CLEAR;
         cnt        <= '0;
         ready      <= 1'b0;
         start_pend <= 1'b0;
         draw_start <= 1'b0;
         draw_bank  <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
         pixel_out  <= BG_COLOR;
         clr_pend   <= 1'b0;
         clr_bank   <= 1'b0;
         clr_addr   <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         start_pend <= init_done | swap;
         draw_start <= start_pend;
         if (init_done)
            ready <= 1'b1;
         if (swap) begin
            draw_bank <= ~draw_bank;
            done      <= 1'b0;
            if (!done && !draw_done)
               overrun <= 1'b1;
         end else if (run && draw_done) begin
            done <= 1'b1;
         end
         pixel_out <= rd_hit ? rd_word : BG_COLOR;
         clr_pend  <= rd_hit;
         clr_addr  <= rd_addr;
         clr_bank  <= ~draw_bank;
      end
   end

   // display bank is the one not selected by draw_bank
   assign rd_word = draw_bank ? mem0[rd_addr] : mem1[rd_addr];

   assign w0    = wr_ok && !draw_bank;
   assign w1    = wr_ok && draw_bank;
   assign caddr = run ? clr_addr : cnt;
   assign c0    = !run || (clr_pend && !clr_bank);
   assign c1    = !run || (clr_pend && clr_bank);

   // clear is written last so it wins over a same-address draw write
   always_ff @(posedge clk) begin
      if (w0)
         mem0[wr_addr] <= wr_data;
      if (c0)
         mem0[caddr] <= BG_COLOR;
   end

   always_ff @(posedge clk) begin
      if (w1)
         mem1[wr_addr] <= wr_data;
      if (c1)
         mem1[caddr] <= BG_COLOR;
   end

endmodule

// File: doc/linebuffer_scanout.md
Name: linebuffer_scanout

Overview:
- Double-buffered (ping-pong) scanline buffer between the pixel-drawing engines (sprite and tile drawers) and the VGA output.
- Drawers write the next line into the draw bank while the current line is read out of the display bank in pixel order.
- Each displayed pixel is cleared to background after it is read.
- On each line boundary the banks swap and the drawers receive a start pulse.

Parameters:
- WIDTH, 640: visible pixels per line; each bank depth.
- PIX_W, 16: pixel data width (bit 0 is the transparency flag on the write side; stored as-is).
- BG_COLOR, 16'h0000: value written by clear operations and driven when not reading.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- line_start  in  1  one-cycle pulse at the start of horizontal blanking; requests a bank swap.
- wr_en  in  1  draw-side write strobe.
- wr_addr  in  10  draw-side pixel column.
- wr_data  in  PIX_W  draw-side pixel.
- draw_done  in  1  level or pulse from the draw engines: the current line is finished.
- rd_en  in  1  active-video qualifier from the VGA counter.
- rd_addr  in  10  display column (0..WIDTH-1).
- pixel_out  out  PIX_W  registered display pixel.
- draw_start  out  1  one-cycle pulse to the draw engines.
- ready  out  1  high once the initial clear is complete.
- draw_bank  out  1  index of the bank currently accepting writes.
- overrun  out  1  sticky: a swap occurred before draw_done.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INIT_CLEAR, clear counter=0.
  - pixel_out=BG_COLOR, draw_start=0, ready=0, draw_bank=0, overrun=0, internal done flag=0.
  - Memory contents are not reset by the reset itself; they are cleared by the INIT_CLEAR sweep.
- INIT_CLEAR:
  - Each cycle writes BG_COLOR at the counter address in both banks, then increments the counter.
  - After the WIDTH-1 write completes (WIDTH cycles), go to RUN, set ready=1, and pulse draw_start the next cycle.
  - wr_en, rd_en and line_start are ignored in this state; pixel_out holds BG_COLOR.
- RUN, write side:
  - wr_en=1 with wr_addr<WIDTH writes wr_data to draw_bank[wr_addr] that cycle.
  - wr_addr>=WIDTH is ignored, with no wrap and no side effect.
- RUN, read side:
  - rd_en=1 and rd_addr<WIDTH: pixel_out at cycle t+1 = display_bank[rd_addr] (latency 1).
  - At cycle t+1, BG_COLOR is written to the same address of the bank that was the display bank at cycle t. The bank select is latched with the address, so a swap between read and clear does not misdirect the clear.
  - rd_en=0 or rd_addr>=WIDTH: pixel_out=BG_COLOR at t+1 and no clear.
- Swap:
  - line_start=1 in RUN toggles draw_bank at the next edge and pulses draw_start one cycle after that.
  - If the done flag is 0 at the swap, set overrun=1 (cleared only by reset). The swap still happens.
  - The done flag is set by draw_done=1 and cleared on each swap. draw_done in the same cycle as line_start counts as done.
- Simultaneous events: line_start and wr_en in the same cycle → the write lands in the pre-swap draw bank.
- Bank port usage:
  - Draw bank takes writes only; display bank takes read plus delayed clear.
  - The two never target the same bank in the same cycle, except a clear pending across a swap. That clear targets the new draw bank, has priority, and is a single cycle; a drawer write to the same address that cycle is dropped.
- Reset mid-line aborts any pending clear and restarts INIT_CLEAR.

Test Plan:
- Release reset → ready=0 for exactly 640 cycles, then ready=1 and draw_start pulses once; reading columns 0..639 returns 16'h0000.
- Write 16'hF800 at addr 5 and 16'h07E0 at addr 639, pulse line_start, read 0..639 with rd_en → pixel_out is 16'hF800 one cycle after rd_addr=5, 16'h07E0 after 639, and 0 elsewhere.
- After that read, two more swaps with no writes, then read again → all pixels 16'h0000 (clear-on-read verified).
- Write at wr_addr=640 and 1023, swap, read → no nonzero pixel, and column 0 is unchanged.
- Pulse line_start without draw_done → overrun=1 and stays 1 across later good lines; draw_done in the same cycle as line_start → overrun stays 0.
- Assert reset low at pixel 300 of a readout → outputs return to reset values immediately; after release, a fresh 640-cycle clear runs and the subsequent read is all 16'h0000.
